// File: rtl/reaction_pkg.sv
// Shared definitions for the two-player reaction game: FSM state codes,
// round-winner codes and default match parameters.
package reaction_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_TIMING = 2'd2,
      S_RESULT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      W_NONE = 2'd0,
      W_P1   = 2'd1,
      W_P2   = 2'd2,
      W_TIE  = 2'd3
   } winner_t;

   localparam int WIN_SCORE_DEF    = 5;
   localparam int MAX_REACT_MS_DEF = 2000;

endpackage

// File: rtl/reaction_judge_sync_edge.sv
// Two-flop synchronizer for a raw player switch followed by a rising-edge
// detector. rise_o is high for one clk when the synchronized level goes 0->1.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchronize the switch and keep one extra delayed copy for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/reaction_judge.sv
// Round judge for the reaction game: detects false starts, times the
// reaction in ms ticks, chooses the round winner and keeps the match score.
// All outputs come straight from registers.
module reaction_judge
   import reaction_pkg::*;
#(
   parameter int TIME_W       = 16,
   parameter int MAX_REACT_MS = MAX_REACT_MS_DEF,
   parameter int SCORE_W      = 4,
   parameter int WIN_SCORE    = WIN_SCORE_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick_ms,
   input  logic               round_start,
   input  logic               go,
   input  logic               sw_p1,
   input  logic               sw_p2,
   output logic [1:0]         state_o,
   output logic [1:0]         winner,
   output logic [TIME_W-1:0]  react_time,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic               false_p1,
   output logic               false_p2,
   output logic               round_done,
   output logic               match_over
);

   localparam logic [TIME_W-1:0]  MAX_T   = TIME_W'(MAX_REACT_MS);
   localparam logic [TIME_W-1:0]  T_SAT   = {TIME_W{1'b1}};
   localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] S_ZERO  = {SCORE_W{1'b0}};
   localparam logic [SCORE_W-1:0] S_ONE   = SCORE_W'(1);

   state_t               state_q, state_d;
   winner_t              winner_q, winner_d;
   logic [TIME_W-1:0]    react_q, react_d, react_inc_s;
   logic [SCORE_W-1:0]   p1_q, p1_d, p2_q, p2_d;
   logic                 f1_q, f1_d, f2_q, f2_d;
   logic                 done_q, done_d, over_q, over_d;
   logic                 flip1_s, flip2_s;

   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
      if (s >= WIN_S) begin
         return WIN_S;
      end else begin
         return s + S_ONE;
      end
   endfunction

   function automatic logic [SCORE_W-1:0] score_dec(input logic [SCORE_W-1:0] s);
      if (s == S_ZERO) begin
         return S_ZERO;
      end else begin
         return s - S_ONE;
      end
   endfunction

   sync_edge u_sync_p1 (.clk(clk), .reset(reset), .async_i(sw_p1), .rise_o(flip1_s));
   sync_edge u_sync_p2 (.clk(clk), .reset(reset), .async_i(sw_p2), .rise_o(flip2_s));

   assign react_inc_s = (react_q == T_SAT) ? react_q : react_q + TIME_W'(1);

   // Judge decisions: next state, winner, timer, scores and status flags.
   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      react_d  = react_q;
      p1_d     = p1_q;
      p2_d     = p2_q;
      f1_d     = f1_q;
      f2_d     = f2_q;
      case (state_q)
         S_IDLE, S_RESULT: begin
            if (round_start && !over_q) begin
               state_d  = S_ARMED;
               winner_d = W_NONE;
               react_d  = {TIME_W{1'b0}};
               f1_d     = 1'b0;
               f2_d     = 1'b0;
            end else begin
               state_d  = state_q;
            end
         end
         S_ARMED: begin
            // A flip is judged before go, so a flip coinciding with go is still false.
            if (flip1_s && flip2_s) begin
               f1_d     = 1'b1;
               f2_d     = 1'b1;
               p1_d     = score_dec(p1_q);
               p2_d     = score_dec(p2_q);
               winner_d = W_NONE;
               state_d  = S_RESULT;
            end else if (flip1_s) begin
               f1_d     = 1'b1;
               p1_d     = score_dec(p1_q);
               winner_d = W_P2;
               state_d  = S_RESULT;
            end else if (flip2_s) begin
               f2_d     = 1'b1;
               p2_d     = score_dec(p2_q);
               winner_d = W_P1;
               state_d  = S_RESULT;
            end else if (go) begin
               react_d  = {TIME_W{1'b0}};
               state_d  = S_TIMING;
            end else begin
               state_d  = S_ARMED;
            end
         end
         S_TIMING: begin
            // Flips win over a simultaneous tick; the tick is then not counted.
            if (flip1_s && flip2_s) begin
               winner_d = W_TIE;
               state_d  = S_RESULT;
            end else if (flip1_s) begin
               winner_d = W_P1;
               p1_d     = score_inc(p1_q);
               state_d  = S_RESULT;
            end else if (flip2_s) begin
               winner_d = W_P2;
               p2_d     = score_inc(p2_q);
               state_d  = S_RESULT;
            end else if (tick_ms) begin
               react_d = react_inc_s;
               if (react_inc_s >= MAX_T) begin
                  winner_d = W_NONE;
                  state_d  = S_RESULT;
               end else begin
                  state_d  = S_TIMING;
               end
            end else begin
               state_d  = S_TIMING;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      done_d = (state_d == S_RESULT) && (state_q != S_RESULT);
      over_d = over_q || (p1_d == WIN_S) || (p2_d == WIN_S);
   end

   // State and output registers; reset clears the whole match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         winner_q <= W_NONE;
         react_q  <= {TIME_W{1'b0}};
         p1_q     <= S_ZERO;
         p2_q     <= S_ZERO;
         f1_q     <= 1'b0;
         f2_q     <= 1'b0;
         done_q   <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         react_q  <= react_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         f1_q     <= f1_d;
         f2_q     <= f2_d;
         done_q   <= done_d;
         over_q   <= over_d;
      end
   end

   assign state_o    = state_q;
   assign winner     = winner_q;
   assign react_time = react_q;
   assign p1_score   = p1_q;
   assign p2_score   = p2_q;
   assign false_p1   = f1_q;
   assign false_p2   = f2_q;
   assign round_done = done_q;
   assign match_over = over_q;

endmodule

// File: tb/tb_reaction_judge.sv
// Scoreboard bench for reaction_judge: randomized rounds are scored by a
// round-level game model; a monitor compares each result on round_done.
module tb_reaction_judge;

   localparam int K_REACT   = 0;
   localparam int K_TIE     = 1;
   localparam int K_FALSE   = 2;
   localparam int K_BOTH    = 3;
   localparam int K_TIMEOUT = 4;
   localparam int WIN       = 5;
   localparam int MAXMS     = 2000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick_ms = 1'b0;
   logic        round_start = 1'b0;
   logic        go = 1'b0;
   logic        sw_p1 = 1'b0;
   logic        sw_p2 = 1'b0;
   logic [1:0]  state_o;
   logic [1:0]  winner;
   logic [15:0] react_time;
   logic [3:0]  p1_score;
   logic [3:0]  p2_score;
   logic        false_p1;
   logic        false_p2;
   logic        round_done;
   logic        match_over;

   reaction_judge dut (
      .clk(clk), .reset(reset), .tick_ms(tick_ms), .round_start(round_start), .go(go),
      .sw_p1(sw_p1), .sw_p2(sw_p2), .state_o(state_o), .winner(winner),
      .react_time(react_time), .p1_score(p1_score), .p2_score(p2_score),
      .false_p1(false_p1), .false_p2(false_p2), .round_done(round_done),
      .match_over(match_over)
   );

   always #5 clk = ~clk;

   typedef struct {
      int win; int rt; int s1; int s2; int f1; int f2; int ov;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   vectors = 0;
   int   miscompares = 0;
   int   m1 = 0, m2 = 0, mov = 0;
   int   last_rt = 0;
   logic prev_done = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Game model at round level: score rules and match end.
   task automatic model(input int kind, input int who, input int n);
      exp_t x;
      x.f1 = 0; x.f2 = 0; x.rt = 0; x.win = 0;
      case (kind)
         K_REACT: begin
            if (who == 1) m1 = (m1 + 1 > WIN) ? WIN : m1 + 1;
            else          m2 = (m2 + 1 > WIN) ? WIN : m2 + 1;
            x.win = who; x.rt = n;
         end
         K_TIE:     begin x.win = 3; x.rt = n; end
         K_FALSE: begin
            if (who == 1) begin m1 = (m1 > 0) ? m1 - 1 : 0; x.f1 = 1; end
            else          begin m2 = (m2 > 0) ? m2 - 1 : 0; x.f2 = 1; end
            x.win = 3 - who;
         end
         K_BOTH: begin
            m1 = (m1 > 0) ? m1 - 1 : 0; m2 = (m2 > 0) ? m2 - 1 : 0;
            x.f1 = 1; x.f2 = 1;
         end
         default: begin x.rt = MAXMS; end
      endcase
      if (m1 == WIN || m2 == WIN) mov = 1;
      x.s1 = m1; x.s2 = m2; x.ov = mov;
      last_rt = x.rt;
      q.push_back(x);
   endtask

   // Monitor: compare each presented round result against the scoreboard.
   always @(negedge clk) begin
      if (!reset && round_done) begin
         chk("done_pulse_width", int'(prev_done), 0);
         if (q.size() == 0) begin
            chk("unexpected_round_done", 1, 0);
         end else begin
            e = q.pop_front();
            chk("res_state", state_o, 3);
            chk("res_winner", winner, e.win);
            chk("res_react_time", react_time, e.rt);
            chk("res_p1_score", p1_score, e.s1);
            chk("res_p2_score", p2_score, e.s2);
            chk("res_false_p1", false_p1, e.f1);
            chk("res_false_p2", false_p2, e.f2);
            chk("res_match_over", match_over, e.ov);
         end
      end
      prev_done = round_done;
   end

   task automatic ticks(input int n);
      repeat (n) begin
         @(negedge clk) tick_ms = 1'b1;
         @(negedge clk) tick_ms = 1'b0;
      end
   endtask

   task automatic arm();
      @(negedge clk) round_start = 1'b1;
      @(negedge clk) round_start = 1'b0;
      chk("armed_state", state_o, 1);
      chk("armed_winner", winner, 0);
      chk("armed_false", int'({false_p1, false_p2}), 0);
   endtask

   // Raise the switches in mask; the decision lands on the third edge.
   task automatic flip(input logic [1:0] mask, input int pre_state,
                       input bit extra_tick, input bit extra_go);
      @(negedge clk);
      if (mask[0]) sw_p1 = 1'b1;
      if (mask[1]) sw_p2 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("latency_hold", state_o, pre_state);
      if (extra_tick) tick_ms = 1'b1;
      if (extra_go) go = 1'b1;
      @(negedge clk) tick_ms = 1'b0;
   endtask

   task automatic wait_done();
      int k = 0;
      while (q.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (q.size() != 0) begin
         chk("round_done_timeout", 0, 1);
         q.delete();
      end
      @(negedge clk);
      chk("rt_hold", react_time, last_rt);
      chk("result_hold", state_o, 3);
   endtask

   task automatic play(input int kind, input int who, input int n,
                       input bit opt_a, input bit opt_pre, input bit opt_drop);
      logic [1:0] mask;
      mask = (who == 1) ? 2'b01 : 2'b10;
      if (opt_pre && kind == K_REACT) begin
         @(negedge clk);
         if (who == 1) sw_p2 = 1'b1; else sw_p1 = 1'b1;
      end
      repeat (4) @(negedge clk);
      arm();
      if (kind == K_FALSE || kind == K_BOTH) begin
         model(kind, who, 0);
         flip((kind == K_BOTH) ? 2'b11 : mask, 1, 1'b0, opt_a);
      end else begin
         @(negedge clk) go = 1'b1;
         @(negedge clk);
         chk("timing_state", state_o, 2);
         if (kind == K_TIMEOUT) begin
            ticks(MAXMS - 1);
            chk("pre_timeout_state", state_o, 2);
            chk("pre_timeout_rt", react_time, MAXMS - 1);
            model(kind, who, 0);
            ticks(1);
         end else begin
            ticks(n);
            if (opt_drop) go = 1'b0;
            model(kind, who, n);
            flip((kind == K_TIE) ? 2'b11 : mask, 2, opt_a, 1'b0);
         end
      end
      wait_done();
      @(negedge clk);
      sw_p1 = 1'b0; sw_p2 = 1'b0; go = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_state"}, state_o, 0);
      chk({tag, "_winner"}, winner, 0);
      chk({tag, "_react_time"}, react_time, 0);
      chk({tag, "_p1_score"}, p1_score, 0);
      chk({tag, "_p2_score"}, p2_score, 0);
      chk({tag, "_false"}, int'({false_p1, false_p2}), 0);
      chk({tag, "_round_done"}, round_done, 0);
      chk({tag, "_match_over"}, match_over, 0);
   endtask

   initial begin
      int guard;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Directed rounds.
      play(K_REACT, 1, 37, 1'b0, 1'b0, 1'b0);
      play(K_REACT, 2, 5, 1'b1, 1'b1, 1'b0);
      play(K_REACT, 2, 9, 1'b0, 1'b0, 1'b1);
      play(K_FALSE, 2, 0, 1'b0, 1'b0, 1'b0);
      play(K_TIE, 1, 10, 1'b0, 1'b0, 1'b0);
      play(K_TIMEOUT, 1, 0, 1'b0, 1'b0, 1'b0);
      play(K_BOTH, 1, 0, 1'b0, 1'b0, 1'b0);
      play(K_FALSE, 1, 0, 1'b1, 1'b0, 1'b0);

      // Randomized rounds until the match ends or the loop budget runs out.
      for (int i = 0; i < 30 && mov == 0; i++) begin
         int r;
         int kind;
         r = $urandom_range(0, 5);
         kind = (r == 5) ? K_REACT : r;
         if (kind == K_TIMEOUT) kind = K_REACT;
         play(kind, $urandom_range(1, 2), $urandom_range(0, 40),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      guard = 0;
      while (mov == 0 && guard < 10) begin
         play(K_REACT, 1, $urandom_range(1, 20), 1'b0, 1'b0, 1'b0);
         guard++;
      end
      chk("match_over_set", match_over, 1);
      chk("final_p1_score", p1_score, m1);
      chk("final_p2_score", p2_score, m2);

      // round_start is ignored once the match is over.
      repeat (3) begin
         @(negedge clk) round_start = 1'b1;
         @(negedge clk) round_start = 1'b0;
         chk("over_state_result", state_o, 3);
         chk("over_no_done", round_done, 0);
         chk("over_held", match_over, 1);
      end

      // Fresh match, scores 3/1, then async reset in the middle of TIMING.
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      m1 = 0; m2 = 0; mov = 0;
      repeat (3) play(K_REACT, 1, 4, 1'b0, 1'b0, 1'b0);
      play(K_REACT, 2, 6, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      arm();
      @(negedge clk) go = 1'b1;
      ticks(12);
      chk("mid_react_time", react_time, 12);
      chk("mid_p1_score", p1_score, 3);
      chk("mid_p2_score", p2_score, 1);
      chk("mid_state", state_o, 2);
      #2 reset = 1'b1;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      go = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
      $fatal(1);
   end

endmodule
